// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: round constants, standard IV, the six bit-mixing
// functions, the working-state struct, the 16-word schedule window type and the
// single-round / schedule-step helpers used by every pipeline stage.
package sha256_pkg;

  // Working variables a..h; a sits in the most significant word so that a
  // 256-bit chaining value maps onto the struct with H0 -> a.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] f;
    logic [31:0] g;
    logic [31:0] h;
  } sha256_state_t;

  // Sliding message-schedule window. Element [15] is the oldest word W[t],
  // element [0] the newest W[t+15], so a 512-bit block with W0 at [511:480]
  // loads directly.
  typedef logic [15:0][31:0] sha256_window_t;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // W[t+16] from the current window (W[t] .. W[t+15]).
  function automatic logic [31:0] next_word(input sha256_window_t win);
    return small_sigma1(win[1]) + win[6] + small_sigma0(win[14]) + win[15];
  endfunction

  // One compression round with round constant k and schedule word w.
  function automatic sha256_state_t sha256_round(input sha256_state_t s,
                                                 input logic [31:0] k,
                                                 input logic [31:0] w);
    sha256_state_t r;
    logic [31:0]   t1;
    logic [31:0]   t2;
    t1  = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
    t2  = big_sigma0(s.a) + maj(s.a, s.b, s.c);
    r.a = t1 + t2;
    r.b = s.a;
    r.c = s.b;
    r.d = s.c;
    r.e = s.d + t1;
    r.f = s.e;
    r.g = s.f;
    r.h = s.g;
    return r;
  endfunction

  // Feed-forward: word-wise iv + final state, H0 in the top word.
  function automatic logic [255:0] add_digest(input logic [255:0] iv,
                                              input sha256_state_t s);
    logic [255:0] sv;
    logic [255:0] d;
    sv = s;
    for (int i = 0; i < 8; i++) begin
      d[255-32*i -: 32] = iv[255-32*i -: 32] + sv[255-32*i -: 32];
    end
    return d;
  endfunction

endpackage

// File: rtl/sha256_pipe_param_stage.sv
// sha256_round_stage: one registered pipeline stage performing
// ROUNDS_PER_STAGE consecutive compression rounds starting at FIRST_ROUND.
// The block's own schedule window, IV copy, tag and valid travel with its
// state, so every stage may hold a different block.
module sha256_round_stage import sha256_pkg::*; #(
  parameter int ROUNDS_PER_STAGE = 1,
  parameter int FIRST_ROUND      = 0,
  parameter int TAG_W            = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  logic           prev_valid,
  input  sha256_state_t  prev_state,
  input  sha256_window_t prev_window,
  input  logic [255:0]   prev_iv,
  input  logic [TAG_W-1:0] prev_tag,
  output logic           valid,
  output sha256_state_t  state,
  output sha256_window_t window,
  output logic [255:0]   iv,
  output logic [TAG_W-1:0] tag
);

  sha256_state_t  state_d;
  sha256_window_t window_d;

  // Chain R rounds; each consumes the oldest window word and slides in W[t+16].
  always_comb begin
    state_d  = prev_state;
    window_d = prev_window;
    for (int r = 0; r < ROUNDS_PER_STAGE; r++) begin
      state_d  = sha256_round(state_d, K[6'(FIRST_ROUND + r)], window_d[15]);
      window_d = {window_d[14:0], next_word(window_d)};
    end
  end

  // Valid bit: cleared by reset, otherwise follows the predecessor on advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (adv) begin
      valid <= prev_valid;
    end
  end

  // Datapath registers are not reset; they only matter when valid is set.
  always_ff @(posedge clk) begin
    if (adv) begin
      state  <= state_d;
      window <= window_d;
      iv     <= prev_iv;
      tag    <= prev_tag;
    end
  end

endmodule

// File: rtl/sha256_pipe_param.sv
// sha256_pipe_param: fully unrolled SHA-256 compression pipeline, one block
// per clock, STAGES = 64/ROUNDS_PER_STAGE round stages between an input
// stage and an output register. ROUNDS_PER_STAGE must be 1, 2, 4 or 8.
// Optional feature macro: SHA256_PIPE_ZERO_CHECK_EN adds out_zero_msw, a
// registered flag that the final digest word H7 (out_digest[31:0]) is zero.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; valid never depends on ready. The whole pipe moves together when
// adv = !out_valid || out_ready, and in_ready = adv, so in_ready is a
// combinational function of out_ready. When adv is 0 every stage holds.
module sha256_pipe_param import sha256_pkg::*; #(
  parameter  int ROUNDS_PER_STAGE = 1,
  parameter  int TAG_W            = 8,
  localparam int STAGES           = 64 / ROUNDS_PER_STAGE,
  localparam int CNT_W            = $clog2(STAGES + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_iv,
  input  logic [511:0]     in_block,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_digest,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] inflight
`ifdef SHA256_PIPE_ZERO_CHECK_EN
  ,
  output logic             out_zero_msw
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic adv;
  logic accept;
  logic handshake;

  // Stage 0 is the input register; stages 1..STAGES are round stages.
  logic           s0_valid;
  sha256_state_t  s0_state;
  sha256_window_t s0_window;
  logic [255:0]   s0_iv;
  logic [TAG_W-1:0] s0_tag;

  logic           st_valid  [0:STAGES];
  sha256_state_t  st_state  [0:STAGES];
  sha256_window_t st_window [0:STAGES];
  logic [255:0]   st_iv     [0:STAGES];
  logic [TAG_W-1:0] st_tag  [0:STAGES];

  logic [255:0] digest_d;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign accept    = in_valid && in_ready;
  assign handshake = out_valid && out_ready;

  assign st_valid[0]  = s0_valid;
  assign st_state[0]  = s0_state;
  assign st_window[0] = s0_window;
  assign st_iv[0]     = s0_iv;
  assign st_tag[0]    = s0_tag;

  // Input stage valid: an empty slot enters on advance when nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= in_valid;
    end
  end

  // Input stage data: working state and IV copy both start from in_iv.
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_state  <= sha256_state_t'(in_iv);
      s0_window <= sha256_window_t'(in_block);
      s0_iv     <= in_iv;
      s0_tag    <= in_tag;
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    sha256_round_stage #(
      .ROUNDS_PER_STAGE(ROUNDS_PER_STAGE),
      .FIRST_ROUND     ((s - 1) * ROUNDS_PER_STAGE),
      .TAG_W           (TAG_W)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .adv        (adv),
      .prev_valid (st_valid[s-1]),
      .prev_state (st_state[s-1]),
      .prev_window(st_window[s-1]),
      .prev_iv    (st_iv[s-1]),
      .prev_tag   (st_tag[s-1]),
      .valid      (st_valid[s]),
      .state      (st_state[s]),
      .window     (st_window[s]),
      .iv         (st_iv[s]),
      .tag        (st_tag[s])
    );
  end

  assign digest_d = add_digest(st_iv[STAGES], st_state[STAGES]);

  // Output register: loads the feed-forward digest when a valid block leaves
  // the last stage; out_valid drops on a handshake with no replacement.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_digest   <= '0;
      out_tag      <= '0;
`ifdef SHA256_PIPE_ZERO_CHECK_EN
      out_zero_msw <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= st_valid[STAGES];
      if (st_valid[STAGES]) begin
        out_digest   <= digest_d;
        out_tag      <= st_tag[STAGES];
`ifdef SHA256_PIPE_ZERO_CHECK_EN
        out_zero_msw <= (digest_d[31:0] == 32'h0);
`endif
      end
    end
  end

  // Occupancy: +1 per accept, -1 per output handshake, both cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else if (accept && !handshake) begin
      inflight <= inflight + CNT_ONE;
    end else if (handshake && !accept) begin
      inflight <= inflight - CNT_ONE;
    end
  end

endmodule
